// File: rtl/prog_loader.sv
// prog_loader
// Loads a program from a valid/ready word stream into the instruction ROM
// write port, then sequences CPU reset/go so the CPU starts at the base
// address. The loader tracks CPU halt so that a new program can be loaded
// with a restart pulse instead of a global reset.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   s_valid/s_ready       word stream handshake
//   s_data, s_last        instruction word, final-word marker
//   base_addr             byte address of the first word and CPU start PC
//   restart               pulse: abandon current activity and start a new load
//   mem_we/addr/wdata     ROM write port, one write per accepted word
//   cpu_reset, cpu_go     CPU sequencing
//   cpu_start_pc          PC the CPU starts from (base captured for this load)
//   cpu_halt              CPU reports halted
//   word_count, checksum  words written and their modular sum for this load
//   load_err              program exceeded DEPTH words
//   busy                  loading or releasing the CPU
module prog_loader #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 32,
   parameter int DEPTH     = 32,
   parameter int ZERO_TERM = 1,
   localparam int CNT_W    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_last,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              restart,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_reset,
   output logic              cpu_go,
   output logic [ADDR_W-1:0] cpu_start_pc,
   input  logic              cpu_halt,
   output logic [CNT_W-1:0]  word_count,
   output logic [DATA_W-1:0] checksum,
   output logic              load_err,
   output logic              busy
);

   localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);
   localparam logic [ADDR_W-1:0] STRIDE  = ADDR_W'(DATA_W / 8);
   localparam logic              ZT      = 1'(ZERO_TERM);

   typedef enum logic [2:0] {
      ST_LOAD    = 3'd0,
      ST_RELEASE = 3'd1,
      ST_RUN     = 3'd2,
      ST_HALTED  = 3'd3,
      ST_ERROR   = 3'd4
   } state_t;

   state_t state;
   state_t next_state;

   logic              do_restart;
   logic              handshake;
   logic              room;
   logic              end_word;
   logic [ADDR_W-1:0] start_eff;

   logic              next_ready;
   logic              next_go;
   logic              next_cpu_reset;
   logic              next_busy;
   logic              next_err;
   logic              next_we;
   logic [ADDR_W-1:0] next_addr;
   logic [CNT_W-1:0]  next_count;
   logic [DATA_W-1:0] next_sum;
   logic [ADDR_W-1:0] next_start;

   // Per-beat decode of the stream and of restart.
   always_comb begin
      // restart is deliberately ignored while the CPU is running
      do_restart = restart && (state != ST_RUN);
      handshake  = s_valid && s_ready && (state == ST_LOAD);
      room       = (word_count < DEPTH_C);
      end_word   = s_last || (ZT && (s_data == {DATA_W{1'b0}}));
      // Until the first word is taken the start PC follows base_addr live,
      // so the first write uses the value sampled on that same edge.
      if (word_count == {CNT_W{1'b0}}) begin
         start_eff = base_addr;
      end else begin
         start_eff = cpu_start_pc;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_LOAD;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state = state;
      if (do_restart) begin
         next_state = ST_LOAD;
      end else begin
         case (state)
            ST_LOAD: begin
               if (handshake) begin
                  if (!room) begin
                     next_state = ST_ERROR;
                  end else if (end_word) begin
                     next_state = ST_RELEASE;
                  end else begin
                     next_state = ST_LOAD;
                  end
               end else begin
                  next_state = ST_LOAD;
               end
            end
            ST_RELEASE: next_state = ST_RUN;
            ST_RUN: begin
               if (cpu_halt) begin
                  next_state = ST_HALTED;
               end else begin
                  next_state = ST_RUN;
               end
            end
            ST_HALTED: next_state = ST_HALTED;
            ST_ERROR:  next_state = ST_ERROR;
            default:   next_state = ST_LOAD;
         endcase
      end
   end

   // Output logic: values every registered output takes at the next edge.
   always_comb begin
      next_ready     = (next_state == ST_LOAD);
      next_go        = (next_state == ST_RELEASE) || (next_state == ST_RUN);
      next_cpu_reset = (next_state == ST_LOAD) || (next_state == ST_RELEASE) ||
                       (next_state == ST_ERROR);
      next_busy      = (next_state == ST_LOAD) || (next_state == ST_RELEASE);
      next_err       = (next_state == ST_ERROR);
      next_we        = handshake && room && !do_restart;
      next_addr      = start_eff + (ADDR_W'(word_count) * STRIDE);
      next_count     = word_count;
      next_sum       = checksum;
      next_start     = cpu_start_pc;
      if (do_restart) begin
         next_count = {CNT_W{1'b0}};
         next_sum   = {DATA_W{1'b0}};
      end else if (state == ST_LOAD) begin
         next_start = start_eff;
         if (next_we) begin
            next_count = word_count + ONE_C;
            next_sum   = checksum + s_data;
         end else begin
            next_count = word_count;
            next_sum   = checksum;
         end
      end else begin
         next_count = word_count;
         next_sum   = checksum;
      end
   end

   // Output and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         s_ready      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= {ADDR_W{1'b0}};
         mem_wdata    <= {DATA_W{1'b0}};
         cpu_reset    <= 1'b1;
         cpu_go       <= 1'b0;
         cpu_start_pc <= {ADDR_W{1'b0}};
         word_count   <= {CNT_W{1'b0}};
         checksum     <= {DATA_W{1'b0}};
         load_err     <= 1'b0;
         busy         <= 1'b1;
      end else begin
         s_ready      <= next_ready;
         mem_we       <= next_we;
         cpu_reset    <= next_cpu_reset;
         cpu_go       <= next_go;
         cpu_start_pc <= next_start;
         word_count   <= next_count;
         checksum     <= next_sum;
         load_err     <= next_err;
         busy         <= next_busy;
         if (next_we) begin
            mem_addr  <= next_addr;
            mem_wdata <= s_data;
         end
      end
   end

endmodule
